// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage; owns the fetch PC, issues in-order imem requests, buffers words for decode
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   incr_pc_i                 decode consumes d_inst_o this cycle
//   redirect_i/redirect_pc_i  taken branch/jump: flush and restart fetch at the target
//   imem_req_o/imem_addr_o    request valid and word-aligned byte address
//   imem_gnt_i                request accepted
//   imem_rvalid_i/imem_rdata_i in-order response
//   d_inst_o/d_pc_o/d_valid_o instruction, its PC and validity toward decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        incr_pc_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] d_inst_o,
    output logic [31:0] d_pc_o,
    output logic        d_valid_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_head_pc;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_kill;

    logic [CW:0]   w_credit;
    logic          w_req;
    logic          w_fire;
    logic          w_rsp;
    logic          w_kill_rsp;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_redir_pc;

    // Buffered words plus in-flight requests never exceed the buffer size, so every response has a slot.
    assign w_credit   = {1'b0, r_count} + {1'b0, r_outst};
    assign w_req      = rst_n_i & ~redirect_i & (w_credit < (CW+1)'(FIFO_DEPTH));
    assign w_fire     = w_req & imem_gnt_i;
    assign w_rsp      = imem_rvalid_i & (r_outst != '0);
    assign w_kill_rsp = w_rsp & (r_kill != '0);
    assign w_push     = w_rsp & ~w_kill_rsp & ~redirect_i;
    assign w_pop      = incr_pc_i & (r_count != '0) & ~redirect_i;
    assign w_redir_pc = redirect_pc_i & ~32'h3;

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_fetch_pc;
    assign d_valid_o   = r_count != '0;
    assign d_inst_o    = d_valid_o ? r_mem[r_rptr] : NOP_INST;
    assign d_pc_o      = r_head_pc;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_fetch_pc <= RESET_PC;
            r_head_pc  <= RESET_PC;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_outst    <= '0;
            r_kill     <= '0;
        end else begin
            r_outst <= r_outst + CW'(w_fire) - CW'(w_rsp);
            if (redirect_i) begin
                r_fetch_pc <= w_redir_pc;
                r_head_pc  <= w_redir_pc;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_count    <= '0;
                // Everything still in flight after this cycle belongs to the old path.
                r_kill     <= r_outst - CW'(w_rsp);
            end else begin
                if (w_fire)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_pop) begin
                    r_head_pc <= r_head_pc + 32'd4;
                    r_rptr    <= r_rptr + 1'b1;
                end
                if (w_push)
                    r_wptr <= r_wptr + 1'b1;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (w_kill_rsp)
                    r_kill <= r_kill - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wptr] <= imem_rdata_i;
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(w_push && r_count == CW'(FIFO_DEPTH)));
    a_kill_le_outst: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        r_kill <= r_outst);
    a_addr_aligned: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        imem_addr_o[1:0] == 2'b00);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed check of fetch_unit with an in-order memory responder
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] TAG = 32'hE000_0000;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        incr_pc_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] d_inst_o;
    logic [31:0] d_pc_o;
    logic        d_valid_o;

    fetch_unit dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .incr_pc_i     (incr_pc_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .d_inst_o      (d_inst_o),
        .d_pc_o        (d_pc_o),
        .d_valid_o     (d_valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst_n;
        logic        incr;
        logic        redir;
        logic [31:0] rpc;
        logic        gnt;
        logic        hold;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] pend[$];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic vec_t mk(logic rst_n, logic incr, logic redir, logic [31:0] rpc, logic gnt, logic hold,
                                logic req, logic [31:0] addr, logic valid, logic [31:0] pc, logic [31:0] inst);
        vec_t v;
        v.rst_n = rst_n; v.incr = incr; v.redir = redir; v.rpc = rpc; v.gnt = gnt; v.hold = hold;
        v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.inst = inst;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    // Memory responder: a granted address returns its word (address tagged with TAG) at least one cycle later.
    task automatic apply(input vec_t v);
        @(negedge clk_i);
        if (!v.rst_n)
            pend.delete();
        rst_n_i       = v.rst_n;
        incr_pc_i     = v.incr;
        redirect_i    = v.redir;
        redirect_pc_i = v.rpc;
        imem_gnt_i    = v.gnt;
        imem_rvalid_i = v.rst_n && !v.hold && pend.size() > 0;
        imem_rdata_i  = imem_rvalid_i ? (pend.pop_front() | TAG) : 32'h0;
        #1;
    endtask

    task automatic note_grant();
        if (imem_req_o && imem_gnt_i)
            pend.push_back(imem_addr_o);
    endtask

    initial begin
        bit got;
        //           rst incr rdr rpc           gnt hold | req addr          vld pc            inst
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0,    0, 32'h0,        0, 32'h0,        NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0,    1, 32'h0,        0, 32'h0,        NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0,    1, 32'h4,        0, 32'h0,        NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0,    0, 32'h8,        1, 32'h0,        32'hE000_0000));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0,    1, 32'h8,        1, 32'h4,        32'hE000_0004));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0,    1, 32'hC,        0, 32'h8,        NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0,    0, 32'h10,       1, 32'h8,        32'hE000_0008));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0,    1, 32'h10,       1, 32'hC,        32'hE000_000C));
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 0,    1, 32'h14,       0, 32'h10,       NOP));
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 0,    0, 32'h18,       1, 32'h10,       32'hE000_0010));
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 0,    0, 32'h18,       1, 32'h10,       32'hE000_0010));
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 0,    0, 32'h18,       1, 32'h10,       32'hE000_0010));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 0,    0, 32'h18,       1, 32'h10,       32'hE000_0010));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 0,    1, 32'h18,       1, 32'h14,       32'hE000_0014));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 0,    1, 32'h18,       0, 32'h18,       NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 0,    1, 32'h18,       0, 32'h18,       NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0,    1, 32'h18,       0, 32'h18,       NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 1,    1, 32'h1C,       0, 32'h18,       NOP));
        tbl.push_back(mk(1, 1, 1, 32'h103,      1, 1,    0, 32'h20,       0, 32'h18,       NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0,    0, 32'h100,      0, 32'h100,      NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0,    1, 32'h100,      0, 32'h100,      NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0,    1, 32'h104,      0, 32'h100,      NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0,    0, 32'h108,      1, 32'h100,      32'hE000_0100));
        tbl.push_back(mk(1, 1, 1, 32'hFFFF_FFFF,1, 0,    0, 32'h108,      1, 32'h104,      32'hE000_0104));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0,    1, 32'hFFFF_FFFC,0, 32'hFFFF_FFFC,NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0,    1, 32'h0,        0, 32'hFFFF_FFFC,NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0,    0, 32'h4,        1, 32'hFFFF_FFFC,32'hFFFF_FFFC));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0,    1, 32'h4,        1, 32'h0,        32'hE000_0000));
        tbl.push_back(mk(0, 1, 0, 32'h0,        1, 0,    0, 32'h0,        0, 32'h0,        NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0,    1, 32'h0,        0, 32'h0,        NOP));

        foreach (tbl[i]) begin
            apply(tbl[i]);
            chk("imem_req_o",  i, {31'b0, imem_req_o}, {31'b0, tbl[i].req});
            chk("imem_addr_o", i, imem_addr_o,         tbl[i].addr);
            chk("d_valid_o",   i, {31'b0, d_valid_o},  {31'b0, tbl[i].valid});
            chk("d_pc_o",      i, d_pc_o,              tbl[i].pc);
            chk("d_inst_o",    i, d_inst_o,            tbl[i].inst);
            note_grant();
        end

        // After reset release, the first word must reach decode within a bounded number of cycles.
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            apply(mk(1, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0));
            got = d_valid_o;
            if (!got)
                note_grant();
        end
        chk("wait_valid",     100, {31'b0, got}, 32'h1);
        chk("post_reset_pc",  100, d_pc_o,       32'h0);
        chk("post_reset_inst",100, d_inst_o,     32'hE000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
